// File: rtl/whack_bot.sv
// Autonomous whack-a-mole player: waits a fixed reaction time after a single mole lights,
// holds the matching button for a fixed time, then waits for that mole to go away.
module whack_bot #(
    parameter int unsigned REACT_CYCLES = 200,
    parameter int unsigned PRESS_CYCLES = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] mole_pos,
    input  logic       game_end,
    output logic [7:0] btn,
    output logic [7:0] press_count,
    output logic       busy,
    output logic       bad_input
);

    // WAIT leaves when the counter already holds REACT_CYCLES, so the button
    // registers the target REACT_CYCLES+1 edges after the mole was sampled.
    localparam logic [15:0] REACT_LAST = 16'(REACT_CYCLES);
    localparam logic [15:0] PRESS_LAST = 16'(PRESS_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        PRESS,
        RELEASE,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  target_q, target_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  btn_q, btn_d;
    logic [7:0]  count_q, count_d;
    logic        bad_q, bad_d;

    logic        mole_one_hot;
    logic        mole_multi_hot;

    assign mole_multi_hot = (mole_pos & (mole_pos - 8'd1)) != 8'd0;
    assign mole_one_hot   = (mole_pos != 8'd0) && !mole_multi_hot;

    always_comb begin
        // NOTE: every variable gets a default first so no path can leave it unassigned and infer a latch.
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        count_d  = count_q;
        bad_d    = bad_q;

        if (game_end) begin
            state_d = DONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mole_multi_hot) begin
                        bad_d = 1'b1;
                    end else if (en && mole_one_hot) begin
                        target_d = mole_pos;
                        cnt_d    = 16'd0;
                        state_d  = WAIT;
                    end
                end
                WAIT: begin
                    // A vanished or moved mole aborts even on the expiry cycle.
                    if (mole_pos != target_q) begin
                        state_d = IDLE;
                    end else if (cnt_q == REACT_LAST) begin
                        cnt_d   = 16'd0;
                        state_d = PRESS;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                PRESS: begin
                    if (cnt_q == PRESS_LAST) begin
                        state_d = RELEASE;
                        if (count_q != 8'hFF) begin
                            count_d = count_q + 8'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                RELEASE: begin
                    if (mole_pos != target_q) begin
                        state_d = IDLE;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Button follows the next state so it is registered together with the state change.
        btn_d = (state_d == PRESS) ? target_d : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= 8'h00;
            cnt_q    <= 16'd0;
            btn_q    <= 8'h00;
            count_q  <= 8'h00;
            bad_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q  <= state_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            btn_q    <= btn_d;
            count_q  <= count_d;
            bad_q    <= bad_d;
        end
    end

    assign btn         = btn_q;
    assign press_count = count_q;
    assign bad_input   = bad_q;
    assign busy        = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_whack_bot.sv
// Self-checking bench for whack_bot: directed timing checks plus a press scoreboard
// that matches every observed button press against queued expectations.
module tb_whack_bot;

    localparam int REACT = 4;
    localparam int PRESS = 3;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] mole_pos;
    logic       game_end;
    logic [7:0] btn;
    logic [7:0] press_count;
    logic       busy;
    logic       bad_input;

    whack_bot #(
        .REACT_CYCLES(REACT),
        .PRESS_CYCLES(PRESS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mole_pos   (mole_pos),
        .game_end   (game_end),
        .btn        (btn),
        .press_count(press_count),
        .busy       (busy),
        .bad_input  (bad_input)
    );

    typedef struct {
        logic [7:0] tgt;
        int         len;
        int         cnt;
    } press_t;

    press_t exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_press(input logic [7:0] tgt, input int len, input int cnt);
        press_t p;
        p.tgt = tgt;
        p.len = len;
        p.cnt = cnt;
        exp_q.push_back(p);
    endtask

    task automatic reset_dut();
        rst      = 1'b1;
        en       = 1'b0;
        mole_pos = 8'h00;
        game_end = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Press monitor: each run of non-zero btn is one press, matched against the queue.
    press_t cur;
    bit     have_cur = 1'b0;
    int     run_len  = 0;

    always @(negedge clk) begin
        check("btn_onehot", 32'($countones(btn) <= 1), 32'd1);
        if (btn != 8'h00) begin
            if (run_len == 0) begin
                if (exp_q.size() == 0) begin
                    have_cur = 1'b0;
                    check("unexpected_press", 32'(btn), 32'd0);
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                end
            end
            if (have_cur) check("press_target", 32'(btn), 32'(cur.tgt));
            run_len++;
        end else if (run_len != 0) begin
            if (have_cur) begin
                check("press_len", 32'(run_len), 32'(cur.len));
                check("press_count_at_release", 32'(press_count), 32'(cur.cnt));
            end
            run_len  = 0;
            have_cur = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset overrides active inputs.
        rst      = 1'b1;
        en       = 1'b1;
        mole_pos = 8'h04;
        game_end = 1'b1;
        tick();
        tick();
        check("rst_btn", 32'(btn), 32'd0);
        check("rst_count", 32'(press_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bad", 32'(bad_input), 32'd0);

        // Basic press: btn on cycles 5..7 after the sampling edge; first edge out of reset samples.
        rst      = 1'b0;
        game_end = 1'b0;
        mole_pos = 8'h04;
        push_press(8'h04, PRESS, 1);
        for (int n = 0; n <= REACT + PRESS + 1; n++) begin
            tick();
            check($sformatf("basic_btn_c%0d", n), 32'(btn),
                  (n >= REACT + 1 && n <= REACT + PRESS) ? 32'h04 : 32'h00);
        end
        check("basic_count", 32'(press_count), 32'd1);
        check("basic_release_busy", 32'(busy), 32'd1);
        mole_pos = 8'h00;
        tick();
        check("basic_back_idle", 32'(busy), 32'd0);

        // Mole disappears during WAIT: no press, count unchanged.
        mole_pos = 8'h10;
        tick();
        tick();
        mole_pos = 8'h00;
        repeat (8) tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_btn", 32'(btn), 32'd0);
        check("abort_count", 32'(press_count), 32'd1);

        // Mismatch on the very expiry edge wins over the transition to PRESS.
        mole_pos = 8'h20;
        repeat (REACT + 1) tick();
        mole_pos = 8'h40;
        tick();
        check("abort_at_expiry_busy", 32'(busy), 32'd0);
        check("abort_at_expiry_btn", 32'(btn), 32'd0);
        mole_pos = 8'h00;
        repeat (2) tick();

        // Held mole is pressed once; a new mole gets its own press.
        reset_dut();
        en       = 1'b1;
        mole_pos = 8'h01;
        push_press(8'h01, PRESS, 1);
        repeat (REACT + PRESS + 2 + 100) tick();
        check("held_still_release", 32'(busy), 32'd1);
        check("held_single_count", 32'(press_count), 32'd1);
        mole_pos = 8'h02;
        push_press(8'h02, PRESS, 2);
        repeat (REACT + PRESS + 3) tick();
        check("second_mole_count", 32'(press_count), 32'd2);
        mole_pos = 8'h00;
        tick();

        // en low blocks new moles; en falling mid-sequence lets it finish.
        reset_dut();
        en       = 1'b0;
        mole_pos = 8'h04;
        repeat (10) tick();
        check("en_low_busy", 32'(busy), 32'd0);
        check("en_low_btn", 32'(btn), 32'd0);
        en = 1'b1;
        push_press(8'h04, PRESS, 1);
        tick();
        tick();
        en = 1'b0;
        repeat (REACT + PRESS) tick();
        check("en_fall_completes", 32'(press_count), 32'd1);
        mole_pos = 8'h00;
        tick();
        mole_pos = 8'h08;
        repeat (10) tick();
        check("en_low_after_busy", 32'(busy), 32'd0);
        check("en_low_after_count", 32'(press_count), 32'd1);

        // game_end cuts a press short and freezes the bot until reset.
        reset_dut();
        en       = 1'b1;
        mole_pos = 8'h08;
        push_press(8'h08, 2, 0);
        repeat (REACT + 3) tick();
        check("ge_mid_press_btn", 32'(btn), 32'h08);
        game_end = 1'b1;
        tick();
        check("ge_btn_drop", 32'(btn), 32'd0);
        check("ge_busy", 32'(busy), 32'd0);
        game_end = 1'b0;
        mole_pos = 8'h00;
        tick();
        mole_pos = 8'h01;
        repeat (20) tick();
        check("done_busy", 32'(busy), 32'd0);
        check("done_btn", 32'(btn), 32'd0);
        check("done_count", 32'(press_count), 32'd0);

        // Reset in the middle of a press drops btn on that edge.
        reset_dut();
        en       = 1'b1;
        mole_pos = 8'h80;
        push_press(8'h80, 1, 0);
        repeat (REACT + 2) tick();
        check("rst_mid_press_btn_on", 32'(btn), 32'h80);
        rst = 1'b1;
        tick();
        check("rst_mid_press_btn_off", 32'(btn), 32'd0);
        rst      = 1'b0;
        mole_pos = 8'h00;
        tick();

        // Multi-hot mole sets the sticky error flag; reset clears it.
        reset_dut();
        en       = 1'b1;
        mole_pos = 8'h03;
        tick();
        check("bad_set", 32'(bad_input), 32'd1);
        check("bad_btn", 32'(btn), 32'd0);
        check("bad_busy", 32'(busy), 32'd0);
        mole_pos = 8'h00;
        repeat (3) tick();
        check("bad_sticky", 32'(bad_input), 32'd1);
        reset_dut();
        check("bad_cleared", 32'(bad_input), 32'd0);

        // 300 moles in a row: count saturates at 255.
        reset_dut();
        en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            mole_pos = 8'(1 << (i % 8));
            push_press(mole_pos, PRESS, (i + 1 > 255) ? 255 : i + 1);
            repeat (REACT + PRESS + 2) tick();
            mole_pos = 8'h00;
            tick();
        end
        check("saturate_count", 32'(press_count), 32'd255);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/whack_bot.md
WHACK_BOT -- requirements
Module: whack_bot

Interface
REQ-001 The module SHALL have a parameter REACT_CYCLES, default 200, setting reaction delay in clk cycles from mole detection to button press (legal range 1..65535).
REQ-002 The module SHALL have a parameter PRESS_CYCLES, default 50, setting button hold time in clk cycles (legal range 1..65535).
REQ-003 The module SHALL have a port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The module SHALL have a port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have a port en, input, 1 bit: 1 = bot plays; 0 = bot stops accepting new moles.
REQ-006 The module SHALL have a port mole_pos, input, 8 bits: one-hot lit mole from the game; all-zero = no mole.
REQ-007 The module SHALL have a port game_end, input, 1 bit: game-over flag from the game.
REQ-008 The module SHALL have a port btn, output, 8 bits: button drive into the game's ui_in; registered.
REQ-009 The module SHALL have a port press_count, output, 8 bits: number of completed presses; registered.
REQ-010 The module SHALL have a port busy, output, 1 bit: 1 when the state is not IDLE or DONE.
REQ-011 The module SHALL have a port bad_input, output, 1 bit: sticky flag, set when mole_pos is multi-hot in IDLE.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, WAIT, PRESS, RELEASE and DONE.
REQ-013 In IDLE, when en=1, game_end=0 and mole_pos has exactly one bit set, the module SHALL latch target=mole_pos, clear the delay counter and enter WAIT.
REQ-014 In IDLE, mole_pos=0 or en=0 SHALL leave the state unchanged.
REQ-015 In IDLE, multi-hot mole_pos SHALL set bad_input and leave the state unchanged.
REQ-016 In WAIT, the counter SHALL increment once per cycle, and after REACT_CYCLES WAIT cycles the state SHALL become PRESS.
REQ-017 Timing: btn SHALL first equal target REACT_CYCLES+1 cycles after the edge that sampled the mole in IDLE.
REQ-018 In WAIT, if mole_pos differs from target on any cycle, the module SHALL abort to IDLE, with no press and no count change.
REQ-019 In PRESS, btn SHALL equal target for exactly PRESS_CYCLES cycles, then the state SHALL become RELEASE.
REQ-020 Entering RELEASE, btn SHALL be 0 and press_count SHALL increment once, saturating at 255 (no wrap).
REQ-021 btn SHALL be 8'h00 in every state except PRESS.
REQ-022 btn SHALL never have more than one bit set.
REQ-023 In RELEASE, the module SHALL stay until mole_pos != target, then enter IDLE, so the same mole is never pressed twice.
REQ-024 A mole_pos change during PRESS SHALL NOT shorten the press.
REQ-025 en falling during WAIT, PRESS or RELEASE SHALL let the current sequence complete, after which IDLE holds.
REQ-026 game_end=1 in any state SHALL force DONE on the next edge, with btn=0 that cycle and busy=0.
REQ-027 game_end SHALL take priority over all other transitions.
REQ-028 DONE SHALL be held until rst, and press_count SHALL be frozen in DONE.
REQ-029 Simultaneous events: game_end SHALL win over the WAIT-to-PRESS expiry, and a mismatch abort SHALL win over expiry in the same cycle.
REQ-030 The delay counter SHALL be 16 bits.

Reset
REQ-031 With rst=1 at a clk edge, the module SHALL enter IDLE with btn=8'h00, press_count=0, busy=0, bad_input=0 and counter=0.
REQ-032 rst SHALL override every input.
REQ-033 rst asserted mid-PRESS SHALL drop btn to 0 on that edge.
REQ-034 On the first edge with rst=0, the module SHALL evaluate IDLE normally.

Verification
REQ-035 REACT=4, PRESS=3; mole_pos=8'h04 held -> btn=8'h04 exactly on cycles 5..7 after sampling edge, then 0; press_count=1.
REQ-036 mole_pos=8'h10, changed to 8'h00 two cycles later (REACT=4) -> btn stays 0, press_count=0, state IDLE.
REQ-037 mole_pos=8'h01 held for 100 cycles after the press -> exactly one press; after mole_pos=8'h02 -> second press on bit 1; press_count=2.
REQ-038 game_end=1 during PRESS -> btn=0 next cycle, busy=0; further moles ignored until rst.
REQ-039 mole_pos=8'h03 in IDLE -> bad_input=1, btn=0; rst -> bad_input=0.
REQ-040 300 back-to-back single moles -> press_count saturates at 255.
